// File: rtl/nx_fifo_pkg.sv
// Shared constants and width helpers for the NanoXplore block-RAM FIFO controller.
package nx_fifo_pkg;

    localparam int RAM_ADDR_W = 16;
    localparam int RAM_DATA_W = 24;

    // Users derive their pointer/count typedefs from these so widths stay tied to ADDR_W.
    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int cnt_w(input int addr_w);
        return addr_w + 2;
    endfunction

    function automatic int skid_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nx_fifo_skid.sv
// First-word-fall-through register FIFO that absorbs RAM read returns.
module nx_fifo_skid
    import nx_fifo_pkg::*;
#(
    parameter  int DATA_W = 24,
    parameter  int DEPTH  = 3,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_err,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_cnt
);
    localparam int IDX_W = idx_w(DEPTH);
    typedef logic [IDX_W-1:0] idx_t;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_err;
    idx_t              r_rd;
    idx_t              r_wr;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_pop;

    function automatic idx_t bump(input idx_t i);
        return (i == idx_t'(DEPTH - 1)) ? '0 : i + idx_t'(1);
    endfunction

    assign o_valid = (r_cnt != '0);
    assign w_pop   = o_valid && i_ready;
    assign o_data  = r_data[r_rd];
    assign o_err   = o_valid && r_err[r_rd];
    assign o_cnt   = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_err <= '0;
            for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
        end else if (i_clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wr] <= i_data;
                r_err[r_wr]  <= i_err;
                r_wr         <= bump(r_wr);
            end
            if (w_pop) r_rd <= bump(r_rd);
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

    // The upstream credit rule guarantees a free slot for every returning word.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_clear && i_push && !w_pop)
            assert (r_cnt < CNT_W'(DEPTH));
    end

endmodule

// File: rtl/nx_ram_fifo_ctrl.sv
// FIFO controller driving a NanoXplore dual-port block RAM (A write, B read) with a prefetch skid buffer.
module nx_ram_fifo_ctrl
    import nx_fifo_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 1,
    parameter int AFULL_TH  = 2**ADDR_W - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  FLUSH,
    input  logic                  W_VALID,
    output logic                  W_READY,
    input  logic [DATA_W-1:0]     W_DATA,
    output logic                  R_VALID,
    input  logic                  R_READY,
    output logic [DATA_W-1:0]     R_DATA,
    output logic                  R_ERR,
    output logic [ADDR_W+1:0]     COUNT,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [7:0]            CORR_CNT,
    output logic [RAM_ADDR_W-1:0] AA,
    output logic                  ACS,
    output logic                  AWE,
    output logic [RAM_DATA_W-1:0] AI,
    output logic [RAM_ADDR_W-1:0] BA,
    output logic                  BCS,
    output logic                  BWE,
    input  logic [RAM_DATA_W-1:0] BO,
    input  logic                  BCOR,
    input  logic                  BERR
);
    localparam int PTR_W   = ptr_w(ADDR_W);
    localparam int CNT_W   = cnt_w(ADDR_W);
    localparam int SKID_D  = skid_depth(RD_LAT);
    localparam int SKID_CW = $clog2(SKID_D + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t OCC_FULL = ptr_t'(2**ADDR_W);

    ptr_t               r_wptr;
    ptr_t               r_rptr;
    ptr_t               w_ram_occ;
    cnt_t               r_count;
    cnt_t               w_count_nxt;
    logic [RD_LAT-1:0]  r_pipe;
    logic [7:0]         r_corr;
    logic               r_afull;
    logic               r_aempty;
    logic               w_wr;
    logic               w_issue;
    logic               w_pop;
    logic               w_capture;
    logic               w_skid_valid;
    logic               w_skid_err;
    logic [SKID_CW-1:0] w_skid_cnt;
    int                 w_inflight;

    // Gating with RN holds W_READY low throughout reset and frees it as soon as RN rises.
    assign w_ram_occ = r_wptr - r_rptr;
    assign W_READY   = RN && (w_ram_occ != OCC_FULL) && !FLUSH;
    assign w_wr      = W_VALID && W_READY;
    assign R_VALID   = w_skid_valid && !FLUSH;
    assign R_ERR     = w_skid_err && R_VALID;
    assign w_pop     = R_VALID && R_READY;
    assign w_capture = r_pipe[RD_LAT-1] && !FLUSH;

    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < RD_LAT; k++) w_inflight = w_inflight + int'(r_pipe[k]);
    end

    // A read is launched only if its return is guaranteed a skid slot.
    assign w_issue = (w_ram_occ != '0) && !FLUSH &&
                     ((int'(w_skid_cnt) + w_inflight - int'(w_pop)) < SKID_D);

    assign w_count_nxt = FLUSH ? '0 : (r_count + cnt_t'(w_wr) - cnt_t'(w_pop));

    assign ACS = w_wr;
    assign AWE = w_wr;
    assign AA  = RAM_ADDR_W'(r_wptr[ADDR_W-1:0]);
    assign AI  = RAM_DATA_W'(W_DATA);
    assign BCS = w_issue;
    assign BWE = 1'b0;
    assign BA  = RAM_ADDR_W'(r_rptr[ADDR_W-1:0]);

    assign COUNT    = r_count;
    assign AFULL    = r_afull;
    assign AEMPTY   = r_aempty;
    assign CORR_CNT = r_corr;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_pipe   <= '0;
            r_count  <= '0;
            r_corr   <= '0;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_afull  <= int'(w_count_nxt) >= AFULL_TH;
            r_aempty <= int'(w_count_nxt) <= AEMPTY_TH;
            if (w_capture && BCOR && (r_corr != 8'hFF)) r_corr <= r_corr + 8'd1;
            if (FLUSH) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_pipe <= '0;
            end else begin
                if (w_wr)    r_wptr <= r_wptr + ptr_t'(1);
                if (w_issue) r_rptr <= r_rptr + ptr_t'(1);
                r_pipe[0] <= w_issue;
                for (int k = 1; k < RD_LAT; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    nx_fifo_skid #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_D)
    ) u_skid (
        .i_clk   (CK),
        .i_rst_n (RN),
        .i_clear (FLUSH),
        .i_push  (w_capture),
        .i_data  (BO[DATA_W-1:0]),
        .i_err   (BERR),
        .o_valid (w_skid_valid),
        .i_ready (R_READY && !FLUSH),
        .o_data  (R_DATA),
        .o_err   (w_skid_err),
        .o_cnt   (w_skid_cnt)
    );

endmodule

// File: tb/tb_nx_ram_fifo_ctrl.sv
// Directed and randomized bench for nx_ram_fifo_ctrl against a queue-based FIFO model and a behavioural RAM.
module tb_nx_ram_fifo_ctrl;
    localparam int DATA_W    = 24;
    localparam int ADDR_W    = 4;
    localparam int RD_LAT    = 2;
    localparam int DEPTH     = 2**ADDR_W;
    localparam int SKID      = RD_LAT + 2;
    localparam int AFULL_TH  = DEPTH - 4;
    localparam int AEMPTY_TH = 4;

    logic              CK = 1'b0;
    logic              RN = 1'b1;
    logic              FLUSH = 1'b0;
    logic              W_VALID = 1'b0;
    logic              R_READY = 1'b0;
    logic [DATA_W-1:0] W_DATA = '0;
    logic              W_READY, R_VALID, R_ERR, AFULL, AEMPTY;
    logic [DATA_W-1:0] R_DATA;
    logic [ADDR_W+1:0] COUNT;
    logic [7:0]        CORR_CNT;
    logic [15:0]       AA, BA;
    logic              ACS, AWE, BCS, BWE;
    logic [23:0]       AI, BO;
    logic              BCOR, BERR;

    nx_ram_fifo_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .CK(CK), .RN(RN), .FLUSH(FLUSH),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_ERR(R_ERR),
        .COUNT(COUNT), .AFULL(AFULL), .AEMPTY(AEMPTY), .CORR_CNT(CORR_CNT),
        .AA(AA), .ACS(ACS), .AWE(AWE), .AI(AI),
        .BA(BA), .BCS(BCS), .BWE(BWE), .BO(BO), .BCOR(BCOR), .BERR(BERR)
    );

    always #5 CK = ~CK;

    // Behavioural block RAM: port A write, port B registered read with RD_LAT stages and ECC flag injection.
    logic [23:0] mem [0:65535];
    logic [25:0] rd_pipe [RD_LAT];
    logic        ecc_en = 1'b0;
    logic        cor_all = 1'b0;
    logic [23:0] cor_val = '0;
    logic [23:0] err_val = '0;

    always @(posedge CK) begin
        if (ACS && AWE) mem[AA] <= AI;
        if (BCS) rd_pipe[0] <= {ecc_en && (mem[BA] == err_val),
                                cor_all || (ecc_en && (mem[BA] == cor_val)), mem[BA]};
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign {BERR, BCOR, BO} = rd_pipe[RD_LAT-1];

    // Scoreboard: bit 24 is the expected error flag, bits 23:0 the word.
    logic [24:0] exp_q[$];
    int n_checks = 0;
    int n_err = 0;

    logic              s_wr, s_pop, s_rvalid, s_rerr, s_bcs, s_wready, s_afull, s_aempty;
    logic [DATA_W-1:0] s_rdata;
    logic [15:0]       s_ba;
    logic [ADDR_W+1:0] s_count;
    int acc, pops, first, bubbles, cmin, cmax, exp_corr, err_word, got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, check against the model, update it, return after the rising edge.
    task automatic tick();
        logic [24:0] head;
        @(negedge CK);
        s_wr = W_VALID && W_READY;  s_pop = R_VALID && R_READY;
        s_rvalid = R_VALID;  s_rdata = R_DATA;  s_rerr = R_ERR;  s_bcs = BCS;  s_ba = BA;
        s_wready = W_READY;  s_count = COUNT;  s_afull = AFULL;  s_aempty = AEMPTY;
        chk("count", COUNT, exp_q.size());
        chk("afull", AFULL, exp_q.size() >= AFULL_TH);
        chk("aempty", AEMPTY, exp_q.size() <= AEMPTY_TH);
        chk("acs", ACS, s_wr);
        chk("awe", AWE, s_wr);
        chk("bwe", BWE, 1'b0);
        if (FLUSH) begin
            chk("flush_wready", W_READY, 1'b0);
            chk("flush_rvalid", R_VALID, 1'b0);
        end else if (exp_q.size() < DEPTH) begin
            chk("wready_room", W_READY, 1'b1);
        end else if (exp_q.size() >= DEPTH + SKID) begin
            chk("wready_full", W_READY, 1'b0);
        end
        if (s_wr) begin
            chk("ai", AI, W_DATA);
            chk("aa_hi", AA[15:ADDR_W], 0);
        end
        if (!R_VALID) chk("rerr_idle", R_ERR, 1'b0);
        if (s_pop) begin
            chk("pop_has_data", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                head = exp_q.pop_front();
                chk("rdata", R_DATA, head[23:0]);
                chk("rerr", R_ERR, head[24]);
            end
        end
        if (s_wr) exp_q.push_back({ecc_en && (W_DATA == err_val), W_DATA});
        if (FLUSH) exp_q.delete();
        @(posedge CK);
        #1;
    endtask

    task automatic drain(input int budget);
        R_READY = 1'b1;
        W_VALID = 1'b0;
        for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1 RN = 1'b0;
        #2;
        chk("rst_wready", W_READY, 1'b0);  chk("rst_rvalid", R_VALID, 1'b0);
        chk("rst_rerr", R_ERR, 1'b0);      chk("rst_afull", AFULL, 1'b0);
        chk("rst_aempty", AEMPTY, 1'b1);   chk("rst_count", COUNT, 0);
        chk("rst_acs", ACS, 1'b0);         chk("rst_bcs", BCS, 1'b0);
        chk("rst_corr", CORR_CNT, 0);
        repeat (2) @(posedge CK);
        #2 RN = 1'b1;
        @(posedge CK);
        #1;

        // Single word: first-read timing and end-to-end latency
        R_READY = 1'b1;
        W_VALID = 1'b1;
        W_DATA  = 24'h00A5A5;
        tick();
        chk("sw_wready_after_rst", s_wready, 1'b1);
        chk("sw_accept", s_wr, 1'b1);
        W_VALID = 1'b0;
        for (int c = 1; c <= RD_LAT + 2; c++) begin
            tick();
            if (c == 1) begin
                chk("sw_bcs", s_bcs, 1'b1);
                chk("sw_ba", s_ba, 0);
            end
            if (c < RD_LAT + 2) chk("sw_rvalid_early", s_rvalid, 1'b0);
            else begin
                chk("sw_rvalid", s_rvalid, 1'b1);
                chk("sw_rdata", s_rdata, 24'h00A5A5);
                chk("sw_count_before_pop", s_count, 1);
            end
        end
        R_READY = 1'b0;
        tick();
        chk("sw_count_after_pop", s_count, 0);

        // Fill with the consumer stalled, then drain with pointer wrap
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            W_VALID = 1'b1;
            W_DATA  = 24'(acc);
            tick();
            if (s_wr) acc++;
        end
        W_VALID = 1'b0;
        chk("fill_accepted", acc, DEPTH + SKID);
        chk("fill_wready_low", s_wready, 1'b0);
        tick();
        chk("fill_count", s_count, DEPTH + SKID);
        chk("fill_afull", s_afull, 1'b1);
        R_READY = 1'b1;
        pops = 0;
        for (int c = 0; c < 80 && pops < acc; c++) begin
            tick();
            if (s_pop) begin
                chk("drain_order", s_rdata, pops);
                pops++;
            end
        end
        chk("drain_all", pops, DEPTH + SKID);
        R_READY = 1'b0;
        tick();
        chk("drain_aempty", s_aempty, 1'b1);

        // Streaming: one word per cycle in both directions
        acc = 0; pops = 0; first = -1; bubbles = 0; cmin = 1000; cmax = -1;
        R_READY = 1'b1;
        for (int c = 0; c < 250 && pops < 100; c++) begin
            W_VALID = (acc < 100);
            W_DATA  = 24'($urandom);
            tick();
            if (s_wr) acc++;
            if (s_pop) begin
                if (first < 0) first = c;
                pops++;
            end else if (first >= 0) bubbles++;
            if (first >= 0 && s_wr) begin
                if (int'(s_count) < cmin) cmin = int'(s_count);
                if (int'(s_count) > cmax) cmax = int'(s_count);
            end
        end
        chk("stream_pops", pops, 100);
        chk("stream_latency", first, RD_LAT + 2);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_count_lo", cmin, SKID);
        chk("stream_count_hi", cmax, SKID);

        // ECC flags travel with their words
        ecc_en = 1'b1; cor_val = 24'hE00003; err_val = 24'hE00005;
        err_word = -1; got = 0;
        R_READY = 1'b1;
        for (int c = 0; c < 60 && got < 8; c++) begin
            W_VALID = (c < 8);
            W_DATA  = 24'hE00000 + 24'(c);
            tick();
            if (s_pop) begin
                if (s_rerr) err_word = got;
                got++;
            end
        end
        ecc_en = 1'b0;
        chk("ecc_words", got, 8);
        chk("ecc_err_word", err_word, 5);
        chk("ecc_corr_cnt", CORR_CNT, 1);
        exp_corr = 1;

        // Corrected-error counter saturation
        cor_all = 1'b1;
        acc = 0;
        for (int c = 0; c < 300; c++) begin
            W_VALID = 1'b1;
            W_DATA  = 24'($urandom);
            tick();
            if (s_wr) acc++;
        end
        drain(40);
        cor_all = 1'b0;
        exp_corr = (exp_corr + acc > 255) ? 255 : exp_corr + acc;
        chk("corr_saturate", CORR_CNT, exp_corr);

        // FLUSH with reads in flight and words in the skid buffer
        R_READY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            W_VALID = 1'b1;
            W_DATA  = 24'($urandom);
            tick();
        end
        FLUSH = 1'b1; W_VALID = 1'b1; R_READY = 1'b1; W_DATA = 24'h000BAD;
        tick();
        chk("flush_no_accept", s_wr, 1'b0);
        chk("flush_no_pop", s_pop, 1'b0);
        FLUSH = 1'b0; W_VALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("flush_rvalid_after", s_rvalid, 1'b0);
            if (c == 0) chk("flush_count", s_count, 0);
        end
        chk("flush_corr_kept", CORR_CNT, exp_corr);
        W_VALID = 1'b1; W_DATA = 24'h000001;
        tick();
        W_VALID = 1'b0;
        got = -1;
        for (int c = 0; c < 20 && got < 0; c++) begin
            tick();
            if (s_pop) got = int'(s_rdata);
        end
        chk("flush_first_after", got, 1);

        // Randomized traffic: filling phase, draining phase, occasional flush
        for (int c = 0; c < 400; c++) begin
            W_VALID = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            R_READY = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            FLUSH   = ($urandom_range(0, 63) == 0);
            W_DATA  = 24'($urandom);
            tick();
        end
        FLUSH = 1'b0;
        drain(60);

        // Asynchronous reset in the middle of a stream
        R_READY = 1'b1;
        for (int c = 0; c < 10; c++) begin
            W_VALID = 1'b1;
            W_DATA  = 24'($urandom);
            tick();
        end
        #2 RN = 1'b0;
        #1;
        chk("arst_wready", W_READY, 1'b0);  chk("arst_rvalid", R_VALID, 1'b0);
        chk("arst_rerr", R_ERR, 1'b0);      chk("arst_afull", AFULL, 1'b0);
        chk("arst_aempty", AEMPTY, 1'b1);   chk("arst_count", COUNT, 0);
        chk("arst_acs", ACS, 1'b0);         chk("arst_awe", AWE, 1'b0);
        chk("arst_bcs", BCS, 1'b0);         chk("arst_corr", CORR_CNT, 0);
        exp_q.delete();
        W_VALID = 1'b0; R_READY = 1'b0;
        @(posedge CK);
        #3 RN = 1'b1;
        @(posedge CK);
        #1;
        W_VALID = 1'b1;
        W_DATA  = 24'($urandom);
        tick();
        chk("post_rst_accept", s_wr, 1'b1);
        drain(20);
        chk("post_rst_corr", CORR_CNT, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
